hub75_bcm_driver: RTL
=====================

// Module: hub75_bcm_driver
// PURPOSE
// - Parametrised HUB75 row driver: true binary-coded modulation (BCM) over COLOR_BITS planes per channel.
// - Takes one row-pair of packed RGB pixels plus a row address over a valid/ready handshake.
// - Shifts each bit plane into the panel, latches it, then lights it for BASE_PERIOD<<plane cycles.
// - Sits between the column/slice buffer and the panel pins.
// PARAMETERS
// - NUM_COLS     64   pixels per shift chain (per half-panel)
// - SCAN_RATE    32   row-pair count; led_addr width = $clog2(SCAN_RATE)
// - COLOR_BITS   3    bits per colour channel (BCM planes)
// - BASE_PERIOD  100  display cycles for plane 0 (LSB), >=1
// PORTS
// - clk_in             in   1                       system clock; only clock
// - rst_in             in   1                       synchronous, active-high reset
// - column_data0       in   [NUM_COLS-1:0][3*COLOR_BITS-1:0]  top-half pixels; pixel p, channel c (0=R,1=G,2=B), plane b at bit c*COLOR_BITS+b
// - column_data1       in   same                    bottom-half pixels, same packing
// - row_addr_in        in   $clog2(SCAN_RATE)       row-pair address for this data
// - tvalid             in   1                       data/address valid
// - tready             out  1                       driver idle, accepting
// - rgb0, rgb1         out  3                       panel data, [0]=R [1]=G [2]=B
// - led_addr           out  $clog2(SCAN_RATE)       panel row address A..E
// - led_clk            out  1                       panel shift clock (registered, never a gated clk_in)
// - led_latch          out  1                       panel latch strobe
// - led_output_enable  out  1                       blank control: 1 = panel dark, 0 = row lit
// BEHAVIOUR
// - Reset: state IDLE; rgb0=rgb1=0, led_clk=0, led_latch=0, led_output_enable=1, led_addr=0, plane=0, counters=0.
// - tready = (state==IDLE), combinational. Reset applied in any state -> IDLE next edge; outputs as above.
// - IDLE: on tvalid&&tready capture both column_data* and row_addr_in into internal regs.
//   Next cycle SHIFT, plane=0. Inputs are ignored outside IDLE.
// - SHIFT (2 cycles/pixel, pixel 0 first):
//   - phase A: led_clk=0, rgb0/rgb1 = plane bits of pixel p.
//   - phase B: led_clk=1, rgb held.
//   - led_output_enable=1 throughout. Plane 0 entry loads led_addr from the captured address.
//   - After phase B of pixel NUM_COLS-1 -> LATCH.
// - LATCH (1 cycle): led_latch=1, led_clk=0, rgb=0, OE=1. Next -> DISPLAY, counter=0.
// - DISPLAY: OE=0, rgb=0, led_latch=0. Counter runs 0..(BASE_PERIOD<<plane)-1.
//   - At terminal count: if plane==COLOR_BITS-1 -> IDLE (OE=1), else plane+1 -> SHIFT.
// - OE is never 0 in SHIFT/LATCH/IDLE; led_clk and led_latch never high together.
// - Frame length, accept to tready high:
//   COLOR_BITS*(2*NUM_COLS+1) + BASE_PERIOD*(2**COLOR_BITS-1) + 1 cycles.
// - tvalid held high: back-to-back frames, exactly 1 IDLE cycle between them.
// - Counter width = $clog2(BASE_PERIOD<<(COLOR_BITS-1)); no wrap inside a window.
// CONFIGURATION
// - HUB75_BRIGHTNESS_EN defined:
//   - Adds port brightness in [7:0], captured with data at accept.
//   - In DISPLAY, OE=0 only while counter < ((BASE_PERIOD<<plane)*brightness)>>8, else OE=1.
//   - Window length is unchanged. brightness=0 -> row never lit.
// - Not defined: port absent; OE=0 for the full DISPLAY window.
// TESTING (NUM_COLS=4, COLOR_BITS=2, BASE_PERIOD=10 unless noted)
// - Reset held 3 cycles -> OE=1, led_clk=0, led_latch=0, rgb0=rgb1=0, led_addr=0, tready=1.
// - All pixels R=2'b11 G=2'b00 B=2'b01, row_addr_in=5 accepted:
//   - plane 0: rgb0=3'b101 on 4 led_clk rises, 1 latch, OE low 10 cycles.
//   - plane 1: rgb0=3'b001, OE low 20 cycles.
//   - led_addr=5; tready high 49 cycles after accept.
// - Pixels 0..3 R-plane0 = 1,0,1,1 -> rgb0[0] at successive led_clk rises is 1,0,1,1.
// - tvalid held high, column_data changed mid-frame -> change ignored; next frame accepted after 1 tready cycle.
// - rst_in pulsed mid-DISPLAY of plane 1 -> next cycle OE=1, led_addr=0, tready=1; no latch follows.
// - HUB75_BRIGHTNESS_EN, brightness=128 -> OE low 5 of 10 and 10 of 20 cycles.
//   brightness=0 -> OE stays 1 all frame.

Source files
------------

// File: rtl/hub75_bcm_driver.sv
// HUB75 row-pair driver: binary-coded modulation over COLOR_BITS planes per channel.
// Optional feature: define HUB75_BRIGHTNESS_EN to add a per-frame 8-bit brightness input.
module hub75_bcm_driver #(
  parameter int NUM_COLS    = 64,
  parameter int SCAN_RATE   = 32,
  parameter int COLOR_BITS  = 3,
  parameter int BASE_PERIOD = 100
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]                             brightness,
`endif
  input  logic [NUM_COLS-1:0][3*COLOR_BITS-1:0]  column_data0,
  input  logic [NUM_COLS-1:0][3*COLOR_BITS-1:0]  column_data1,
  input  logic [$clog2(SCAN_RATE)-1:0]           row_addr_in,
  input  logic                                   tvalid,
  output logic                                   tready,
  output logic [2:0]                             rgb0,
  output logic [2:0]                             rgb1,
  output logic [$clog2(SCAN_RATE)-1:0]           led_addr,
  output logic                                   led_clk,
  output logic                                   led_latch,
  output logic                                   led_output_enable
);

  localparam int PW     = 3 * COLOR_BITS;
  localparam int XW     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int PLW    = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int CW_RAW = $clog2(BASE_PERIOD << (COLOR_BITS - 1));
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t                       state;
  logic [NUM_COLS-1:0][PW-1:0]  data0_q, data1_q;
  logic [XW-1:0]                pix;
  logic [PLW-1:0]               plane;
  logic [CW-1:0]                cnt;
  logic [CW-1:0]                win_last;
  logic                         lit_next;

  // Pick {B,G,R} of one plane for one pixel; channel c plane b sits at c*COLOR_BITS+b.
  function automatic logic [2:0] plane_bits(input logic [NUM_COLS-1:0][PW-1:0] d,
                                            input logic [XW-1:0] p,
                                            input logic [PLW-1:0] b);
    logic [PW-1:0] px;
    px = d[p] >> b;
    return {px[2*COLOR_BITS], px[COLOR_BITS], px[0]};
  endfunction

  assign tready   = (state == IDLE);
  assign win_last = CW'((BASE_PERIOD << plane) - 1);

`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]    bright_q;
  logic [CW-1:0] cnt_next;
  logic [31:0]   lit_len;
  // Lit portion sits at the start of each window; the window length itself never changes.
  assign cnt_next = (state == DISPLAY) ? cnt + CW'(1) : '0;
  assign lit_len  = ((32'(BASE_PERIOD) << plane) * 32'(bright_q)) >> 8;
  assign lit_next = 32'(cnt_next) < lit_len;
`else
  assign lit_next = 1'b1;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      rgb0              <= '0;
      rgb1              <= '0;
      led_clk           <= 1'b0;
      led_latch         <= 1'b0;
      led_output_enable <= 1'b1;
      led_addr          <= '0;
      plane             <= '0;
      pix               <= '0;
      cnt               <= '0;
      data0_q           <= '0;
      data1_q           <= '0;
`ifdef HUB75_BRIGHTNESS_EN
      bright_q          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rgb0              <= '0;
          rgb1              <= '0;
          led_clk           <= 1'b0;
          led_latch         <= 1'b0;
          led_output_enable <= 1'b1;
          if (tvalid) begin
            data0_q  <= column_data0;
            data1_q  <= column_data1;
            led_addr <= row_addr_in;
`ifdef HUB75_BRIGHTNESS_EN
            bright_q <= brightness;
`endif
            // First pixel is presented straight from the inputs so shifting starts next cycle.
            rgb0     <= plane_bits(column_data0, XW'(0), PLW'(0));
            rgb1     <= plane_bits(column_data1, XW'(0), PLW'(0));
            plane    <= '0;
            pix      <= '0;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // led_clk doubles as the phase bit: low = data set up, high = panel samples.
          if (!led_clk) begin
            led_clk <= 1'b1;
          end else begin
            led_clk <= 1'b0;
            if (pix == XW'(NUM_COLS - 1)) begin
              led_latch <= 1'b1;
              rgb0      <= '0;
              rgb1      <= '0;
              state     <= LATCH;
            end else begin
              pix  <= pix + XW'(1);
              rgb0 <= plane_bits(data0_q, pix + XW'(1), plane);
              rgb1 <= plane_bits(data1_q, pix + XW'(1), plane);
            end
          end
        end
        LATCH: begin
          led_latch         <= 1'b0;
          cnt               <= '0;
          led_output_enable <= !lit_next;
          state             <= DISPLAY;
        end
        DISPLAY: begin
          if (cnt == win_last) begin
            led_output_enable <= 1'b1;
            if (plane == PLW'(COLOR_BITS - 1)) begin
              state <= IDLE;
            end else begin
              plane <= plane + PLW'(1);
              pix   <= '0;
              rgb0  <= plane_bits(data0_q, XW'(0), plane + PLW'(1));
              rgb1  <= plane_bits(data1_q, XW'(0), plane + PLW'(1));
              state <= SHIFT;
            end
          end else begin
            cnt               <= cnt + CW'(1);
            led_output_enable <= !lit_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Panel safety: never clock and latch together, never light outside a display window.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      assert (!(led_clk && led_latch) && (led_output_enable || state == DISPLAY));
    end
  end

endmodule
